// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Run/halt/single-step sequencer and read-after-write interlock for the
// 3-stage 8-bit pipeline (IF/ID -> ID/EX -> EX/WB -> register file).
// A small shadow of the EX and WB destinations tracks the writes that are
// still in flight.
// Build option FWD_EN: forwarding selects replace stalls. Hazards are never
// raised, and stall_cnt stays at zero.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | after reset; nothing fetched, ID/EX held at NOP
// FILL   | warm-up; fetching but IF/ID not yet valid, NOPs issued
// RUN    | normal issue
// STALL  | RAW hazard on the ID instruction; fetch frozen, NOP issued
// DRAIN  | halting; NOPs issued for DRAIN_CYCLES cycles
// HALTED | parked; waits for start (resume) or step (one instruction)
// STEP   | issue exactly one instruction (waiting out any hazard), then drain
module pipe_hazard_ctrl #(
    parameter int FILL_CYCLES  = 2,
    parameter int DRAIN_CYCLES = 2,
    parameter int STALL_CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   halt_req,
    input  logic                   step,
    input  logic [7:0]             id_instr,
    output logic                   pc_en,
    output logic                   ifid_en,
    output logic                   idex_bubble,
    output logic [1:0]             fwd_a_sel,
    output logic [1:0]             fwd_b_sel,
    output logic [2:0]             state,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FILL   = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_STALL  = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam logic [2:0] S_HALTED = 3'd5;
    localparam logic [2:0] S_STEP   = 3'd6;

    // One down-counter serves both FILL and DRAIN.
    localparam int CNT_MAX = (FILL_CYCLES > DRAIN_CYCLES) ? FILL_CYCLES : DRAIN_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] FILL_LOAD  = CNT_W'(FILL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    logic [2:0]             state_q, state_d, state_eff;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [2:0]             ex_dst_q, wb_dst_q;
    logic                   ex_wr_q, wb_wr_q;

    logic       id_nop;
    logic [2:0] id_rs1, id_rs2;
    logic       rs1_ex, rs1_wb, rs2_ex, rs2_wb;
    logic       hazard;

    assign id_nop = (id_instr[7:6] == 2'b00);
    assign id_rs1 = id_instr[2:0];
    assign id_rs2 = id_instr[5:3];

    // A NOP reads nothing, so it never matches anything in flight.
    assign rs1_ex = !id_nop && ex_wr_q && (id_rs1 == ex_dst_q);
    assign rs1_wb = !id_nop && wb_wr_q && (id_rs1 == wb_dst_q);
    assign rs2_ex = !id_nop && ex_wr_q && (id_rs2 == ex_dst_q);
    assign rs2_wb = !id_nop && wb_wr_q && (id_rs2 == wb_dst_q);

`ifdef FWD_EN
    // The younger result (EX) wins when both stages write the same register.
    assign hazard    = 1'b0;
    assign fwd_a_sel = rs1_ex ? 2'b01 : (rs1_wb ? 2'b10 : 2'b00);
    assign fwd_b_sel = rs2_ex ? 2'b01 : (rs2_wb ? 2'b10 : 2'b00);
`else
    // The register file does not write through, so a WB match also stalls.
    assign hazard    = rs1_ex | rs1_wb | rs2_ex | rs2_wb;
    assign fwd_a_sel = 2'b00;
    assign fwd_b_sel = 2'b00;
`endif

    assign state     = state_eff;
    assign stall_cnt = stall_cnt_q;

    // RUN/STALL resolve against the live hazard; pipeline controls follow the resolved state.
    always_comb begin
        state_eff = state_q;
        if ((state_q == S_RUN) || (state_q == S_STALL)) begin
            state_eff = hazard ? S_STALL : S_RUN;
        end
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_bubble = 1'b1;
        case (state_eff)
            S_FILL: begin
                pc_en   = 1'b1;
                ifid_en = 1'b1;
            end
            S_RUN: begin
                pc_en       = 1'b1;
                ifid_en     = 1'b1;
                idex_bubble = 1'b0;
            end
            S_STEP: begin
                if (!hazard) begin
                    pc_en       = 1'b1;
                    ifid_en     = 1'b1;
                    idex_bubble = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Next state, FILL/DRAIN timer and saturating stall counter.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (((state_eff == S_STALL) || ((state_q == S_STEP) && hazard)) &&
            (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_FILL;
                    cnt_d       = FILL_LOAD;
                    stall_cnt_d = '0;
                end
            end
            S_FILL: begin
                if (cnt_q == '0) state_d = S_RUN;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_RUN, S_STALL: begin
                // Halt beats a hazard; the instruction left in IF/ID is refetched by the caller.
                if (halt_req) begin
                    state_d = S_DRAIN;
                    cnt_d   = DRAIN_LOAD;
                end else begin
                    state_d = state_eff;
                end
            end
            S_DRAIN: begin
                if (cnt_q == '0) state_d = S_HALTED;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_HALTED: begin
                if (start)     state_d = S_RUN;
                else if (step) state_d = S_STEP;
            end
            S_STEP: begin
                if (!hazard) begin
                    state_d = S_DRAIN;
                    cnt_d   = DRAIN_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Shadow destinations shift every cycle; a bubble or a NOP carries no write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_dst_q <= '0;
            ex_wr_q  <= 1'b0;
            wb_dst_q <= '0;
            wb_wr_q  <= 1'b0;
        end else begin
            ex_dst_q <= id_rs2;
            ex_wr_q  <= !idex_bubble && !id_nop;
            wb_dst_q <= ex_dst_q;
            wb_wr_q  <= ex_wr_q;
        end
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Sequencing and hazard controller for the 3-stage 8-bit pipeline (IF/ID -> ID/EX -> EX/WB -> register file).
- Owns the run/halt/single-step state machine.
- Drives the fetch and IF/ID enables.
- Inserts bubbles into ID/EX when the instruction in ID reads a register still being written by an older instruction.
- Keeps its own shadow of in-flight destinations and a saturating stall counter.

Parameters:
FILL_CYCLES, 2, cycles spent in FILL before RUN (pipeline warm-up)
DRAIN_CYCLES, 2, bubble cycles inserted when draining before HALTED
STALL_CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-low
start  in  1  pulse; leave IDLE/HALTED and begin fetching
halt_req  in  1  pulse; stop fetching, drain, enter HALTED
step  in  1  pulse; in HALTED, issue exactly one instruction, then re-halt
id_instr  in  8  IF/ID instruction register; [7:6] opcode, [2:0] rs1, [5:3] rs2 (rs2 is also the destination)
pc_en  out  1  fetch/PC advance enable
ifid_en  out  1  IF/ID load enable; 0 holds the current instruction
idex_bubble  out  1  1 = ID/EX loads RegWrite=0, AluOp=0 (NOP)
fwd_a_sel  out  2  operand A source: 00 RF, 01 EX result, 10 WB result
fwd_b_sel  out  2  operand B source, same encoding
state  out  3  IDLE=0, FILL=1, RUN=2, STALL=3, DRAIN=4, HALTED=5, STEP=6
stall_cnt  out  STALL_CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Decode: opcode 00 is a NOP with no reads and no write. Any other opcode reads rs1 and rs2 and writes rs2.
- Register file is not write-through. A write is visible to ID only the cycle after the instruction leaves WB.
- Shadow pipeline: ex_dst/ex_wr and wb_dst/wb_wr registers.
  - Each cycle, ID contents shift into EX (ex_wr=0 when idex_bubble=1 or the instruction is a NOP), and EX shifts into WB.
  - Shift occurs in every state.
- Hazard (combinational): the ID instruction is non-NOP and (rs1 or rs2) equals ex_dst with ex_wr=1, or equals wb_dst with wb_wr=1.
- Reset values: state=IDLE, pc_en=0, ifid_en=0, idex_bubble=1, fwd_*_sel=00, stall_cnt=0, shadow ex_wr=wb_wr=0.
- IDLE: pc_en=ifid_en=0, bubble=1.
  - start -> FILL; stall_cnt cleared on this transition.
- FILL: pc_en=ifid_en=1, bubble=1 (IF/ID not yet valid).
  - Down-counter from FILL_CYCLES-1; at 0 -> RUN.
- RUN: pc_en=ifid_en=1, bubble=0.
  - hazard -> STALL in the same cycle: outputs switch combinationally to stall values.
- STALL: pc_en=ifid_en=0, bubble=1; stall_cnt +1 per cycle, saturating at all-ones.
  - hazard cleared -> RUN (same-cycle outputs).
  - Worst case vs EX: 2 stall cycles. Vs WB only: 1.
- halt_req in RUN or STALL -> DRAIN.
  - Takes priority over a hazard.
  - The ID instruction is discarded and refetch is the caller's responsibility.
- DRAIN: pc_en=ifid_en=0, bubble=1 for DRAIN_CYCLES, then -> HALTED.
- HALTED: same outputs as DRAIN.
  - start -> RUN.
  - step -> STEP.
  - start and step together: start wins.
- STEP: issue one instruction, pc_en=ifid_en=1, bubble=0 for one cycle, then -> DRAIN.
  - If a hazard exists, stay in STEP with stall outputs until it clears. These cycles count in stall_cnt.
- start in RUN/STALL/FILL is ignored. halt_req in IDLE/FILL/HALTED/STEP is ignored.
- Asynchronous reset mid-operation: immediate return to reset values; the shadow pipeline is cleared.

Optional Feature:
FWD_EN.
- Defined:
  - fwd_a_sel/fwd_b_sel are driven from the rs1/rs2 match: EX match has priority over WB match, giving 01/10.
  - Hazard is never asserted, so STALL is unreachable and stall_cnt stays 0.
- Undefined: fwd_*_sel are constant 00 and hazard stalls apply as above.

Test Plan:
1. Reset low mid-RUN -> all outputs at reset values within the same cycle, state=0, stall_cnt=0; after release, state stays 0 until start.
2. start, then independent instrs 8'h41, 8'h8A -> FILL for 2 cycles, then RUN; no bubbles, stall_cnt=0.
3. 8'h50 (writes r2) immediately followed by 8'h52 (reads r2) -> 2 STALL cycles with pc_en=0, bubble=1; stall_cnt=2. With FWD_EN: 0 stalls, fwd_a_sel=01 then the consumer proceeds.
4. Dependency with one independent instr between -> 1 stall cycle, stall_cnt=1. With FWD_EN: fwd_b_sel=10.
5. halt_req during STALL -> DRAIN for 2 cycles, then HALTED; halt wins over hazard. step -> exactly one cycle with pc_en=1, then DRAIN, then HALTED.
6. Force stall_cnt near saturation via a long hazard chain with STALL_CNT_W=2 -> count holds at 3.
